// File: rtl/pio_pkg.sv
// Shared definitions for the PIO core and its register-bus bridge.
// Holds action codes, register offsets, bridge FSM encoding and decode record.
// No logic; the codes here must stay in step with the core.
package pio_pkg;

    // Action codes understood by the core on its strobe interface
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;
    localparam logic [3:0] ACT_INTR  = 4'd11;

    // Per-machine register offsets (addr[3:0] when addr[6]=0)
    localparam logic [3:0] REG_PEND    = 4'd0;
    localparam logic [3:0] REG_GRPS    = 4'd1;
    localparam logic [3:0] REG_DIV     = 4'd2;
    localparam logic [3:0] REG_SHIFT   = 4'd3;
    localparam logic [3:0] REG_TXF     = 4'd4;
    localparam logic [3:0] REG_RXF     = 4'd5;
    localparam logic [3:0] REG_IMM     = 4'd6;
    localparam logic [3:0] REG_EN      = 4'd7;
    localparam logic [3:0] REG_INTR    = 4'd8;
    localparam logic [3:0] REG_VERSION = 4'd9;

    localparam logic [31:0] VERSION_VAL = 32'h0100_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIFO,
        ST_ISSUE,
        ST_CAPTURE,
        ST_COOLDOWN,
        ST_RESP
    } state_t;

    // Decoded request, latched at accept
    typedef struct packed {
        logic       rd;       // read request
        logic       wait_tx;  // TXF push: wait for TX space
        logic       wait_rx;  // RXF pull: wait for RX data
        logic       version;  // VERSION read: constant data, no core action
        logic [3:0] action;
        logic [1:0] mindex;
        logic [4:0] index;
    } dec_t;

endpackage

// File: rtl/pio_bus_bridge.sv
// Register-bus bridge: decodes host requests into one-cycle PIO core action strobes.
// Latency accept->rsp_valid: 3 cycles (read/write), +FIFO wait cycles, 1 cycle on decode error.
// Backpressure: req_ready only in IDLE; FIFO accesses stall until flag clears or TIMEOUT expires.
module pio_bus_bridge
    import pio_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        pio_action,
    output logic [1:0]        pio_mindex,
    output logic [4:0]        pio_index,
    output logic [31:0]       pio_din,
    input  logic [31:0]       pio_dout,
    input  logic [3:0]        pio_tx_full,
    input  logic [3:0]        pio_rx_empty
);

    state_t          state, state_nxt;
    dec_t            dec_in, dec_q, dec_cur;
    logic            dec_err;
    logic [31:0]     wdata_q, wdata_cur;
    logic [TO_W-1:0] to_cnt;
    logic            accept, fifo_ok, timed_out;

    // Address/direction decode; hi flags nonzero address bits above [6:0]
    function automatic dec_t decode(input logic wr, input logic [6:0] a,
                                    input logic hi, output logic err);
        dec_t d;
        d        = '0;
        err      = 1'b0;
        d.rd     = !wr;
        d.mindex = a[5:4];
        if (hi) begin
            err = 1'b1;
        end else if (a[6]) begin
            d.mindex = 2'd0;
            d.action = ACT_INSTR;
            d.index  = a[4:0];
            err      = !wr;
        end else begin
            case (a[3:0])
                REG_PEND:    begin d.action = ACT_PEND;  err = !wr; end
                REG_GRPS:    begin d.action = ACT_GRPS;  err = !wr; end
                REG_DIV:     begin d.action = ACT_DIV;   err = !wr; end
                REG_SHIFT:   begin d.action = ACT_SHIFT; err = !wr; end
                REG_IMM:     begin d.action = ACT_IMM;   err = !wr; end
                REG_TXF:     begin d.action = ACT_PUSH;  d.wait_tx = 1'b1; err = !wr; end
                REG_RXF:     begin d.action = ACT_PULL;  d.wait_rx = 1'b1; err = wr; end
                REG_EN:      begin d.action = ACT_EN;    d.mindex = 2'd0;  err = !wr; end
                REG_INTR:    begin d.action = ACT_INTR;  err = wr; end
                REG_VERSION: begin d.version = 1'b1;     err = wr; end
                default:     err = 1'b1;
            endcase
        end
        return d;
    endfunction

    // Decode the live request and select the source for strobe fields
    always_comb begin
        dec_err   = 1'b0;
        dec_in    = '0;
        dec_in    = decode(req_write, req_addr[6:0], |(req_addr >> 7), dec_err);
        accept    = req_valid && req_ready;
        dec_cur   = (state == ST_IDLE) ? dec_in : dec_q;
        wdata_cur = (state == ST_IDLE) ? req_wdata : wdata_q;
        fifo_ok   = (dec_q.wait_tx && !pio_tx_full[dec_q.mindex]) ||
                    (dec_q.wait_rx && !pio_rx_empty[dec_q.mindex]);
        // Error fires on the TIMEOUT-th wait cycle without the flag clearing
        timed_out = (to_cnt == TO_W'(TIMEOUT - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_err)                              state_nxt = ST_RESP;
                    else if (dec_in.wait_tx || dec_in.wait_rx) state_nxt = ST_WAIT_FIFO;
                    else                                      state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT_FIFO: begin
                if (fifo_ok)        state_nxt = ST_ISSUE;
                else if (timed_out) state_nxt = ST_RESP;
            end
            ST_ISSUE:    state_nxt = dec_q.rd ? ST_CAPTURE : ST_COOLDOWN;
            ST_CAPTURE:  state_nxt = ST_RESP;
            ST_COOLDOWN: state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State, latched request, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dec_q      <= '0;
            wdata_q    <= '0;
            to_cnt     <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            pio_action <= ACT_NONE;
            pio_mindex <= '0;
            pio_index  <= '0;
            pio_din    <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);
            // RESP is reached from IDLE only on a decode error, from WAIT_FIFO only on timeout
            rsp_err   <= (state_nxt == ST_RESP) &&
                         (state == ST_IDLE || state == ST_WAIT_FIFO);
            // Core dout was registered at the ISSUE edge; take it during CAPTURE
            if (state == ST_CAPTURE) rsp_rdata <= dec_q.version ? VERSION_VAL : pio_dout;
            else                     rsp_rdata <= '0;
            if (accept) begin
                dec_q   <= dec_in;
                wdata_q <= req_wdata;
            end
            // Zero outside WAIT_FIFO so each wait starts from 0; saturate inside
            if (state != ST_WAIT_FIFO)       to_cnt <= '0;
            else if (to_cnt != {TO_W{1'b1}}) to_cnt <= to_cnt + 1'b1;
            if (state_nxt == ST_ISSUE) begin
                pio_action <= dec_cur.action;
                pio_mindex <= dec_cur.mindex;
                pio_index  <= dec_cur.index;
                pio_din    <= dec_cur.rd ? 32'd0 : wdata_cur;
            end else begin
                pio_action <= ACT_NONE;
                pio_mindex <= '0;
                pio_index  <= '0;
                pio_din    <= '0;
            end
        end
    end

endmodule
